risc_spm_core: RTL and testbench
================================

# risc_spm_core

Parametrised RISC-SPM processor core: datapath plus an integrated multi-cycle control state machine, replacing the externally sequenced processing unit. Word width and register-file size are parameters. Adds carry and negative flags, two new branches, illegal-opcode detection, and a ready-based memory handshake that tolerates wait states. Sits between the instruction/data memory and the system top level.

## Interface
- WORD_W, 8, data/address/instruction width; must satisfy WORD_W ≥ 4 + 2·REG_AW
- REG_AW, 2, register index width; register count is 2^REG_AW
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- mem_addr  out  WORD_W  memory address (address register)
- mem_wr_data  out  WORD_W  write data (source register)
- mem_rd_data  in  WORD_W  read data
- mem_req  out  1  memory access request
- mem_we  out  1  write qualifier for mem_req
- mem_ready  in  1  access completes on an edge where mem_req && mem_ready
- pc  out  WORD_W  program counter
- zflag, cflag, nflag  out  1  zero, carry/borrow, negative flags
- halted  out  1  core stopped
- illegal  out  1  stopped on an undefined opcode

## Operation
- Instruction format: [W-1:W-4] opcode, then src field (REG_AW bits), then dest field (REG_AW bits) in the LSBs; remaining bits ignored.
- Opcodes: NOP 0, ADD 1, SUB 2, AND 3, NOT 4, RD 5, WR 6, BR 7, BRZ 8, BRC 9, BRN A, HALT F. Codes B–E are illegal.
- ADD: dest ← src + dest, C = carry out. SUB: dest ← src − dest, C = 1 when src < dest (borrow). AND: dest ← src & dest, C ← 0. NOT: dest ← ~src, C ← 0. Every ALU op sets Z = (result == 0) and N = result MSB. All other instructions leave the flags unchanged.
- RD, WR, BR, BRZ, BRC and BRN are two-word instructions; the second word is an absolute address.
- RD: dest ← mem[addr]. WR: mem[addr] ← src. BR: pc ← addr. BRZ/BRC/BRN: branch when Z/C/N = 1; otherwise the operand word is skipped with pc+1 and no memory access.
- States:
  - IDLE → FET1.
  - FET1: addr ← pc.
  - FET2: request; on ready, IR ← rd_data, pc+1.
  - DEC: dispatch.
  - EX1: Y ← src; ADD/SUB/AND only.
  - EX2: dest/flags ← ALU; NOT enters EX2 directly from DEC.
  - OP1: addr ← pc.
  - OP2: request; on ready, addr ← rd_data, pc+1 (branches: pc ← rd_data, then → FET1).
  - RD3: read; on ready, dest ← data.
  - WR3: write; on ready.
  - HALT.
- Completing states and not-taken branches return to FET1. HALT and illegal opcodes enter HALT, which is exited only by reset. illegal = 1 only when the halt was caused by an undefined opcode.

## Timing
- Reset values: all registers, IR, Y, pc, mem_addr, flags, halted and illegal are 0; mem_req = mem_we = 0; state = IDLE.
- Asserting reset mid-access aborts the access immediately. No write may complete after reset asserts.
- mem_req is high only in FET2, OP2, RD3 and WR3. mem_we is high only in WR3. mem_addr and mem_wr_data are stable while mem_req is high.
- Each cycle with mem_req=1 and mem_ready=0 holds the state and all registers unchanged; each such cycle adds one cycle of latency.
- Zero-wait latency, FET1 to next FET1:
  - NOP and not-taken branch: 3 cycles.
  - NOT: 4.
  - ADD/SUB/AND: 5.
  - Taken branch: 5.
  - RD and WR: 6.
- pc wraps from 2^W−1 to 0. Address and data arithmetic is modulo 2^W.
- halted and illegal assert on the edge entering HALT.

## Structure
- Shared package risc_spm_pkg holds the opcode constants, the state enumeration and the field-position constants derived from WORD_W/REG_AW.
- The register file, IR, Y, pc and address register are inline registers. Bus muxes are combinational.
- One sub-module: risc_spm_alu (combinational; result plus Z/C/N, parametrised by WORD_W), instantiated once.

## Test plan
- Reset mid-WR3 with mem_ready=0: all outputs return to their reset values at once; no mem_we pulse is accepted; after release, the first mem_req occurs in FET2 with mem_addr=0x00.
- With mem[0x80]=0x7F and mem[0x81]=0x01, run RD R0,0x80; RD R1,0x81; ADD 0x14 → R0=0x80, N=1, Z=0, C=0; the ADD takes 5 cycles.
- Continue with RD R0,0x81 then SUB 0x24 → R0=0x00, Z=1, C=0. Then BRZ 0x40 → pc=0x40 after 5 cycles. Then BRC with C=0 → not taken, pc advances by 2, 3 cycles.
- Hold mem_ready=0 for 3 cycles during FET2 of a NOP → IR and pc are unchanged while held; the NOP takes 6 cycles.
- WR from R2=0x5A to address 0xA5 → the accepted cycle shows mem_we=1, mem_addr=0xA5, mem_wr_data=0x5A; flags are unchanged.
- Opcode 0xF0 → halted=1, illegal=0, mem_req stays 0 indefinitely. Opcode 0xB0 → halted=1, illegal=1.

Source files
------------

// File: rtl/risc_spm_pkg.sv
// Shared constants for the RISC-SPM core: opcodes, control states, ALU operations and
// instruction field positions.
package risc_spm_pkg;

  localparam int unsigned OpcW = 4;

  localparam logic [OpcW-1:0] OpNop  = 4'h0;
  localparam logic [OpcW-1:0] OpAdd  = 4'h1;
  localparam logic [OpcW-1:0] OpSub  = 4'h2;
  localparam logic [OpcW-1:0] OpAnd  = 4'h3;
  localparam logic [OpcW-1:0] OpNot  = 4'h4;
  localparam logic [OpcW-1:0] OpRd   = 4'h5;
  localparam logic [OpcW-1:0] OpWr   = 4'h6;
  localparam logic [OpcW-1:0] OpBr   = 4'h7;
  localparam logic [OpcW-1:0] OpBrz  = 4'h8;
  localparam logic [OpcW-1:0] OpBrc  = 4'h9;
  localparam logic [OpcW-1:0] OpBrn  = 4'hA;
  localparam logic [OpcW-1:0] OpHalt = 4'hF;

  localparam int unsigned StW = 4;

  localparam logic [StW-1:0] StIdle = 4'd0;
  localparam logic [StW-1:0] StFet1 = 4'd1;
  localparam logic [StW-1:0] StFet2 = 4'd2;
  localparam logic [StW-1:0] StDec  = 4'd3;
  localparam logic [StW-1:0] StEx1  = 4'd4;
  localparam logic [StW-1:0] StEx2  = 4'd5;
  localparam logic [StW-1:0] StOp1  = 4'd6;
  localparam logic [StW-1:0] StOp2  = 4'd7;
  localparam logic [StW-1:0] StRd3  = 4'd8;
  localparam logic [StW-1:0] StWr3  = 4'd9;
  localparam logic [StW-1:0] StHalt = 4'd10;

  typedef enum logic [1:0] {AluAdd, AluSub, AluAnd, AluNot} alu_op_e;

  // Opcode occupies the top OpcW bits, src sits just above dest, dest is in the LSBs.
  localparam int unsigned DestLsb = 0;

  function automatic int unsigned opc_lsb(input int unsigned word_w);
    return word_w - OpcW;
  endfunction

  function automatic int unsigned src_lsb(input int unsigned reg_aw);
    return reg_aw;
  endfunction

  function automatic logic is_branch(input logic [OpcW-1:0] opc);
    return (opc == OpBr) || (opc == OpBrz) || (opc == OpBrc) || (opc == OpBrn);
  endfunction

endpackage

// File: rtl/risc_spm_if.sv
// Memory bus between the RISC-SPM core (master) and instruction/data memory (slave).
interface risc_spm_if #(
  parameter int unsigned WORD_W = 8
) ();

  logic [WORD_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wr_data;
  logic [WORD_W-1:0] mem_rd_data;
  logic              mem_req;
  logic              mem_we;
  logic              mem_ready;

  modport master (
    output mem_addr,
    output mem_wr_data,
    output mem_req,
    output mem_we,
    input  mem_rd_data,
    input  mem_ready
  );

  modport slave (
    input  mem_addr,
    input  mem_wr_data,
    input  mem_req,
    input  mem_we,
    output mem_rd_data,
    output mem_ready
  );

endinterface

// File: rtl/risc_spm_alu.sv
// Combinational ALU for the RISC-SPM core: result plus zero, carry/borrow and negative flags.
module risc_spm_alu
  import risc_spm_pkg::*;
#(
  parameter int unsigned WORD_W = 8
) (
  input  alu_op_e           op_i,
  input  logic [WORD_W-1:0] a_i,
  input  logic [WORD_W-1:0] b_i,
  output logic [WORD_W-1:0] result_o,
  output logic              zero_o,
  output logic              carry_o,
  output logic              neg_o
);

  always_comb begin
    result_o = '0;
    carry_o  = 1'b0;
    unique case (op_i)
      AluAdd: {carry_o, result_o} = {1'b0, a_i} + {1'b0, b_i};
      AluSub: begin
        result_o = a_i - b_i;
        carry_o  = (a_i < b_i);
      end
      AluAnd: result_o = a_i & b_i;
      AluNot: result_o = ~a_i;
      default: result_o = '0;
    endcase
    zero_o = (result_o == '0);
    neg_o  = result_o[WORD_W-1];
  end

endmodule

// File: rtl/risc_spm_core.sv
// RISC-SPM processor core: register file, datapath and multi-cycle control FSM with a
// ready-based memory handshake. WORD_W must be at least 4 + 2*REG_AW.
module risc_spm_core
  import risc_spm_pkg::*;
#(
  parameter int unsigned WORD_W = 8,
  parameter int unsigned REG_AW = 2
) (
  input  logic              clk,
  input  logic              rst,
  risc_spm_if.master        mem,
  output logic [WORD_W-1:0] pc,
  output logic              zflag,
  output logic              cflag,
  output logic              nflag,
  output logic              halted,
  output logic              illegal
);

  localparam int          NumRegs = 2 ** REG_AW;
  localparam int unsigned OpcLsb  = opc_lsb(WORD_W);
  localparam int unsigned SrcLsb  = src_lsb(REG_AW);
  localparam logic [WORD_W-1:0] One = {{(WORD_W-1){1'b0}}, 1'b1};

  logic [WORD_W-1:0] regs_q [NumRegs];
  logic [WORD_W-1:0] ir_q, ir_d;
  logic [WORD_W-1:0] y_q, y_d;
  logic [WORD_W-1:0] pc_q, pc_d;
  logic [WORD_W-1:0] addr_q, addr_d;
  logic [StW-1:0]    state_q, state_d;
  logic              z_q, z_d, c_q, c_d, n_q, n_d;
  logic              halted_q, halted_d, illegal_q, illegal_d;

  logic              reg_we;
  logic [WORD_W-1:0] reg_wd;

  logic [OpcW-1:0]   opcode;
  logic [REG_AW-1:0] src, dest;

  assign opcode = ir_q[OpcLsb +: OpcW];
  assign src    = ir_q[SrcLsb +: REG_AW];
  assign dest   = ir_q[DestLsb +: REG_AW];

  // ALU: NOT reads src directly from DEC; two-operand ops use the latched Y.
  alu_op_e           alu_op;
  logic [WORD_W-1:0] alu_a, alu_res;
  logic              alu_z, alu_c, alu_n;

  always_comb begin
    case (opcode)
      OpAdd:   alu_op = AluAdd;
      OpSub:   alu_op = AluSub;
      OpAnd:   alu_op = AluAnd;
      default: alu_op = AluNot;
    endcase
  end

  assign alu_a = (opcode == OpNot) ? regs_q[src] : y_q;

  risc_spm_alu #(
    .WORD_W (WORD_W)
  ) u_alu (
    .op_i     (alu_op),
    .a_i      (alu_a),
    .b_i      (regs_q[dest]),
    .result_o (alu_res),
    .zero_o   (alu_z),
    .carry_o  (alu_c),
    .neg_o    (alu_n)
  );

  // Bus outputs come straight from registers so they stay stable through wait states.
  assign mem.mem_addr    = addr_q;
  assign mem.mem_wr_data = regs_q[src];
  assign mem.mem_req     = (state_q == StFet2) || (state_q == StOp2) ||
                           (state_q == StRd3)  || (state_q == StWr3);
  assign mem.mem_we      = (state_q == StWr3);

  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    y_d       = y_q;
    pc_d      = pc_q;
    addr_d    = addr_q;
    z_d       = z_q;
    c_d       = c_q;
    n_d       = n_q;
    halted_d  = halted_q;
    illegal_d = illegal_q;
    reg_we    = 1'b0;
    reg_wd    = alu_res;

    case (state_q)
      StIdle: state_d = StFet1;
      StFet1: begin
        addr_d  = pc_q;
        state_d = StFet2;
      end
      StFet2: begin
        if (mem.mem_ready) begin
          ir_d    = mem.mem_rd_data;
          pc_d    = pc_q + One;
          state_d = StDec;
        end
      end
      StDec: begin
        case (opcode)
          OpNop:                     state_d = StFet1;
          OpAdd, OpSub, OpAnd:       state_d = StEx1;
          OpNot:                     state_d = StEx2;
          OpRd, OpWr, OpBr:          state_d = StOp1;
          OpBrz, OpBrc, OpBrn: begin
            if ((opcode == OpBrz && z_q) || (opcode == OpBrc && c_q) ||
                (opcode == OpBrn && n_q)) begin
              state_d = StOp1;
            end else begin
              pc_d    = pc_q + One;
              state_d = StFet1;
            end
          end
          OpHalt: begin
            halted_d = 1'b1;
            state_d  = StHalt;
          end
          default: begin
            halted_d  = 1'b1;
            illegal_d = 1'b1;
            state_d   = StHalt;
          end
        endcase
      end
      StEx1: begin
        y_d     = regs_q[src];
        state_d = StEx2;
      end
      StEx2: begin
        reg_we  = 1'b1;
        z_d     = alu_z;
        c_d     = alu_c;
        n_d     = alu_n;
        state_d = StFet1;
      end
      StOp1: begin
        addr_d  = pc_q;
        state_d = StOp2;
      end
      StOp2: begin
        if (mem.mem_ready) begin
          if (is_branch(opcode)) begin
            pc_d    = mem.mem_rd_data;
            state_d = StFet1;
          end else begin
            pc_d    = pc_q + One;
            addr_d  = mem.mem_rd_data;
            state_d = (opcode == OpRd) ? StRd3 : StWr3;
          end
        end
      end
      StRd3: begin
        if (mem.mem_ready) begin
          reg_we  = 1'b1;
          reg_wd  = mem.mem_rd_data;
          state_d = StFet1;
        end
      end
      StWr3: begin
        if (mem.mem_ready) state_d = StFet1;
      end
      StHalt:  state_d = StHalt;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      ir_q      <= '0;
      y_q       <= '0;
      pc_q      <= '0;
      addr_q    <= '0;
      z_q       <= 1'b0;
      c_q       <= 1'b0;
      n_q       <= 1'b0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      y_q       <= y_d;
      pc_q      <= pc_d;
      addr_q    <= addr_d;
      z_q       <= z_d;
      c_q       <= c_d;
      n_q       <= n_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NumRegs; i++) regs_q[i] <= '0;
    end else if (reg_we) begin
      regs_q[dest] <= reg_wd;
    end
  end

  assign pc      = pc_q;
  assign zflag   = z_q;
  assign cflag   = c_q;
  assign nflag   = n_q;
  assign halted  = halted_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_risc_spm_core.sv
// Directed bench for risc_spm_core: memory model with programmable wait states, fetch-start
// log for FET1-to-FET1 latencies, and a write log for accepted stores.
module tb_risc_spm_core;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] pc;
  logic         zflag, cflag, nflag, halted, illegal;

  always #5 clk = ~clk;

  risc_spm_if #(.WORD_W(W)) bus ();

  risc_spm_core #(
    .WORD_W (W),
    .REG_AW (2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .mem     (bus),
    .pc      (pc),
    .zflag   (zflag),
    .cflag   (cflag),
    .nflag   (nflag),
    .halted  (halted),
    .illegal (illegal)
  );

  // Memory model: image is loaded into mem_arr while reset is held.
  logic [7:0]  image   [256];
  logic [7:0]  mem_arr [256];
  logic [7:0]  stall_addr;
  int          stall_len;
  int          held;
  logic        stall_now;
  int          wn;
  int          wr_total = 0;
  logic [15:0] wlog [8];

  assign stall_now       = bus.mem_req && (bus.mem_addr == stall_addr) && (held < stall_len);
  assign bus.mem_ready   = !stall_now;
  assign bus.mem_rd_data = mem_arr[bus.mem_addr];

  always @(posedge clk) begin
    if (!rst) begin
      mem_arr <= image;
      held    <= 0;
      wn      <= 0;
    end else begin
      if (stall_now) held <= held + 1;
      if (bus.mem_req && bus.mem_we && bus.mem_ready) begin
        mem_arr[bus.mem_addr] <= bus.mem_wr_data;
        if (wn < 8) wlog[wn[2:0]] <= {bus.mem_addr, bus.mem_wr_data};
        wn       <= wn + 1;
        wr_total <= wr_total + 1;
      end
    end
  end

  // A rising mem_req that is not a write marks FET2 (or OP2) one cycle after FET1/OP1.
  int         cyc;
  logic       req_prev;
  int         fetch_cyc   [256];
  logic [2:0] fetch_flags [256];

  always @(negedge clk) begin
    if (!rst) begin
      cyc      <= 0;
      req_prev <= 1'b0;
      for (int i = 0; i < 256; i++) fetch_cyc[i] <= -1;
    end else begin
      cyc      <= cyc + 1;
      req_prev <= bus.mem_req;
      if (bus.mem_req && !req_prev && !bus.mem_we) begin
        fetch_cyc[bus.mem_addr]   <= cyc;
        fetch_flags[bus.mem_addr] <= {zflag, cflag, nflag};
      end
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_image();
    for (int i = 0; i < 256; i++) image[i] = 8'h00;
  endtask

  initial begin
    int n;
    int reqs;

    // ---- Reset aborts a stalled write ----
    clear_image();
    image[8'h00] = 8'h60;  // WR R0
    image[8'h01] = 8'hA5;
    image[8'hA5] = 8'h33;
    stall_addr   = 8'hA5;
    stall_len    = 1000;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_pc", pc, 0);
    check("rst_flags", {zflag, cflag, nflag}, 0);
    check("rst_halted", {halted, illegal}, 0);
    check("rst_req", {bus.mem_req, bus.mem_we}, 0);
    check("rst_addr", bus.mem_addr, 0);
    rst = 1'b1;
    n = 0;
    while (!(bus.mem_req && bus.mem_we) && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("wr3_reached", bus.mem_we, 1);
    repeat (2) @(negedge clk);
    check("wr3_addr", bus.mem_addr, 8'hA5);
    check("wr3_held_req", bus.mem_req, 1);
    #2 rst = 1'b0;
    #1;
    check("abort_req", {bus.mem_req, bus.mem_we}, 0);
    check("abort_pc", pc, 0);
    check("abort_addr", bus.mem_addr, 0);
    check("abort_state", {zflag, cflag, nflag, halted, illegal}, 0);
    repeat (3) @(negedge clk);
    check("abort_no_write", wr_total, 0);
    stall_len = 0;
    rst = 1'b1;
    n = 0;
    while (n < 10) begin
      @(negedge clk);
      n++;
      if (bus.mem_req) break;
    end
    check("first_req_cycle", n, 2);
    check("first_req_addr", bus.mem_addr, 0);

    // ---- Main program ----
    rst = 1'b0;
    clear_image();
    image[8'h00] = 8'h50; image[8'h01] = 8'h80;  // RD R0,0x80
    image[8'h02] = 8'h51; image[8'h03] = 8'h81;  // RD R1,0x81
    image[8'h04] = 8'h14;                        // ADD R1,R0
    image[8'h05] = 8'h60; image[8'h06] = 8'hB0;  // WR R0,0xB0
    image[8'h07] = 8'h50; image[8'h08] = 8'h81;  // RD R0,0x81
    image[8'h09] = 8'h24;                        // SUB R1,R0
    image[8'h0A] = 8'h60; image[8'h0B] = 8'hB1;  // WR R0,0xB1
    image[8'h0C] = 8'h80; image[8'h0D] = 8'h40;  // BRZ 0x40
    image[8'h40] = 8'h90; image[8'h41] = 8'h10;  // BRC 0x10 (not taken)
    image[8'h42] = 8'h00;                        // NOP, fetched with 3 wait states
    image[8'h43] = 8'h52; image[8'h44] = 8'h90;  // RD R2,0x90
    image[8'h45] = 8'h68; image[8'h46] = 8'hA5;  // WR R2,0xA5
    image[8'h47] = 8'hF0;                        // HALT
    image[8'h80] = 8'h7F;
    image[8'h81] = 8'h01;
    image[8'h90] = 8'h5A;
    image[8'hB0] = 8'hEE;
    image[8'hB1] = 8'hEE;
    stall_addr = 8'h42;
    stall_len  = 3;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    n = 0;
    while (!halted && n < 300) begin
      @(negedge clk);
      n++;
      if (bus.mem_req && bus.mem_addr == 8'h42 && !bus.mem_ready) begin
        check("nop_hold_pc", pc, 8'h42);
      end
    end
    check("main_halted", halted, 1);
    check("main_illegal", illegal, 0);
    check("main_pc", pc, 8'h48);
    check("lat_rd", fetch_cyc[8'h02] - fetch_cyc[8'h00], 6);
    check("lat_add", fetch_cyc[8'h05] - fetch_cyc[8'h04], 5);
    check("lat_wr", fetch_cyc[8'h07] - fetch_cyc[8'h05], 6);
    check("lat_sub", fetch_cyc[8'h0A] - fetch_cyc[8'h09], 5);
    check("lat_brz_taken", fetch_cyc[8'h40] - fetch_cyc[8'h0C], 5);
    check("lat_brc_not_taken", fetch_cyc[8'h42] - fetch_cyc[8'h40], 3);
    check("lat_nop_wait", fetch_cyc[8'h43] - fetch_cyc[8'h42], 6);
    check("flags_after_add", fetch_flags[8'h05], 3'b001);
    check("flags_after_sub", fetch_flags[8'h0A], 3'b100);
    check("flags_after_wr", fetch_flags[8'h47], 3'b100);
    check("write_count", wn, 3);
    check("write_add_result", wlog[0], 16'hB080);
    check("write_sub_result", wlog[1], 16'hB100);
    check("write_r2", wlog[2], 16'hA55A);
    reqs = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.mem_req) reqs++;
    end
    check("halt_quiet", reqs, 0);

    // ---- Illegal opcode ----
    rst = 1'b0;
    clear_image();
    image[8'h00] = 8'hB0;
    stall_len = 0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    n = 0;
    while (!halted && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("ill_halted", halted, 1);
    check("ill_illegal", illegal, 1);
    check("ill_pc", pc, 8'h01);
    reqs = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.mem_req) reqs++;
    end
    check("ill_quiet", reqs, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
